// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first, one bit per clock.
// Ports: clk, rst_n, start, A, B in; busy, done, sum, cout out (all registered).
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_d;

   logic [WIDTH-1:0] sa, sb, acc;
   logic [CW-1:0]    cnt;
   logic             c;
   logic             s, g, last;

   assign s    = sa[0] ^ sb[0] ^ c;
   assign g    = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
   assign last = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // busy/done are flopped from the next state so they stay glitch-free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
         sa   <= '0;
         sb   <= '0;
         acc  <= '0;
         c    <= 1'b0;
         cnt  <= '0;
      end else begin
         busy <= (state_d != IDLE);
         done <= (state_d == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  sa  <= A;
                  sb  <= B;
                  c   <= 1'b0;
                  cnt <= '0;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               c   <= g;
               acc <= {s, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               // final bit lands directly in the result register
               if (last) begin
                  sum  <= {s, acc[WIDTH-1:1]};
                  cout <= g;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=4 instances).
// Arithmetic reference model, per-cycle compare, directed literal vectors.
module tb_bit_serial_adder;

   logic clk = 1'b0;
   logic rst_n;

   logic       ts[2];
   logic [7:0] ta[2];
   logic [7:0] tb_b[2];

   logic       o_busy[2];
   logic       o_done[2];
   logic       o_cout[2];
   logic [7:0] o_sum[2];
   logic [3:0] sum4;

   int checks   = 0;
   int failures = 0;
   int ndone[2];
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(8)) dut8 (
      .clk  (clk),
      .rst_n(rst_n),
      .start(ts[0]),
      .A    (ta[0]),
      .B    (tb_b[0]),
      .busy (o_busy[0]),
      .done (o_done[0]),
      .sum  (o_sum[0]),
      .cout (o_cout[0])
   );

   bit_serial_adder #(.WIDTH(4)) dut4 (
      .clk  (clk),
      .rst_n(rst_n),
      .start(ts[1]),
      .A    (ta[1][3:0]),
      .B    (tb_b[1][3:0]),
      .busy (o_busy[1]),
      .done (o_done[1]),
      .sum  (sum4),
      .cout (o_cout[1])
   );

   assign o_sum[1] = {4'b0, sum4};

   function automatic int wof(int d);
      return (d == 0) ? 8 : 4;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counts edges since acceptance, result is plain A+B.
   logic m_busy[2];
   int   m_cnt[2];
   int   m_res[2];
   int   m_sum[2];
   logic m_cout[2];

   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_busy[d] <= 1'b0;
            m_cnt[d]  <= 0;
            m_res[d]  <= 0;
            m_sum[d]  <= 0;
            m_cout[d] <= 1'b0;
         end else if (!m_busy[d]) begin
            if (ts[d]) begin
               m_busy[d] <= 1'b1;
               m_cnt[d]  <= 0;
               m_res[d]  <= int'(ta[d] & 8'((1 << wof(d)) - 1))
                          + int'(tb_b[d] & 8'((1 << wof(d)) - 1));
            end
         end else if (m_cnt[d] == wof(d)) begin
            m_busy[d] <= 1'b0;
         end else begin
            m_cnt[d] <= m_cnt[d] + 1;
            if (m_cnt[d] + 1 == wof(d)) begin
               m_sum[d]  <= m_res[d] & ((1 << wof(d)) - 1);
               m_cout[d] <= (m_res[d] >> wof(d)) & 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", wof(d)), 32'(o_busy[d]), 32'(m_busy[d]));
            chk($sformatf("done%0d", wof(d)), 32'(o_done[d]),
                32'(m_busy[d] && m_cnt[d] == wof(d)));
            chk($sformatf("sum%0d", wof(d)), 32'(o_sum[d]), 32'(m_sum[d]));
            chk($sformatf("cout%0d", wof(d)), 32'(o_cout[d]), 32'(m_cout[d]));
            if (o_done[d] === 1'b1) ndone[d]++;
         end
      end
   end

   task automatic run_op(int d, int a, int b, int es, int ec);
      int lat;
      @(negedge clk);
      ta[d]   = 8'(a);
      tb_b[d] = 8'(b);
      ts[d]   = 1'b1;
      @(negedge clk);
      ts[d] = 1'b0;
      lat   = 1;
      chk("op_busy", 32'(o_busy[d]), 32'd1);
      while (o_done[d] !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("op_lat a=%0d b=%0d", a, b), 32'(lat - 1), 32'(wof(d)));
      chk($sformatf("op_sum a=%0d b=%0d", a, b), 32'(o_sum[d]), 32'(es));
      chk($sformatf("op_cout a=%0d b=%0d", a, b), 32'(o_cout[d]), 32'(ec));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int first, second, s1, s2, pulses, nd;
      for (int d = 0; d < 2; d++) begin
         ts[d]   = 1'b0;
         ta[d]   = '0;
         tb_b[d] = '0;
         ndone[d] = 0;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", 32'(o_busy[d]), 32'd0);
         chk("rst_done", 32'(o_done[d]), 32'd0);
         chk("rst_sum", 32'(o_sum[d]), 32'd0);
         chk("rst_cout", 32'(o_cout[d]), 32'd0);
      end
      chk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 3, 5, 8, 0);
      run_op(0, 8'hFF, 8'h01, 8'h00, 1);
      run_op(0, 8'hFF, 8'hFF, 8'hFE, 1);

      // start held high, operands changed mid-run
      @(negedge clk);
      ta[0]   = 8'h10;
      tb_b[0] = 8'h20;
      ts[0]   = 1'b1;
      first = 0; second = 0; s1 = 0; s2 = 0; pulses = 0;
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk);
         if (i == 2) begin
            ta[0]   = 8'h01;
            tb_b[0] = 8'h01;
         end
         if (o_done[0] === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = i;
               s1    = int'(o_sum[0]);
            end else if (second == 0) begin
               second = i;
               s2     = int'(o_sum[0]);
            end
         end
      end
      ts[0] = 1'b0;
      chk("held_first_done", 32'(first), 32'd9);
      chk("held_first_sum", 32'(s1), 32'h30);
      chk("held_second_done", 32'(second), 32'd19);
      chk("held_second_sum", 32'(s2), 32'd2);
      chk("held_pulses", 32'(pulses), 32'd2);
      @(negedge clk);
      chk("held_idle", 32'(o_busy[0]), 32'd0);

      run_op(0, 8'h10, 8'h20, 8'h30, 0);

      // reset in the middle of an operation
      @(negedge clk);
      ta[0]   = 8'hAA;
      tb_b[0] = 8'h11;
      ts[0]   = 1'b1;
      @(negedge clk);
      ts[0] = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      nd = ndone[0];
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(o_busy[0]), 32'd0);
      chk("mid_rst_done", 32'(o_done[0]), 32'd0);
      chk("mid_rst_sum", 32'(o_sum[0]), 32'd0);
      chk("mid_rst_cout", 32'(o_cout[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      chk("mid_rst_no_done", 32'(ndone[0]), 32'(nd));
      run_op(0, 7, 9, 16, 0);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op(1, a, b, (a + b) & 15, (a + b) >> 4);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential, bit-serial counterpart to the lab's combinational full subtractor. It adds two WIDTH-bit unsigned operands, LSB first, one bit per clock, through a single full-adder cell and a registered carry. It sits beside the subtractor lab blocks as the addition side of the same arithmetic set. A start/busy/done handshake and a stable result register let a bench or a controller sequence operations.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 2..32.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled only in IDLE
- A  input  WIDTH  operand A; captured on the accepting edge only
- B  input  WIDTH  operand B; captured on the accepting edge only
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; sum/cout valid from this cycle on
- sum  output  WIDTH  registered result (A + B) mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE after WIDTH bit steps.
  - DONE -> IDLE unconditionally.
- Accepting edge (IDLE, start=1):
  - load shift registers sa<=A and sb<=B
  - clear internal carry c<=0
  - clear bit counter cnt<=0
- Each RUN edge processes bit cnt:
  - s = sa[0] ^ sb[0] ^ c
  - c <= (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]))
  - s is shifted into the MSB of an internal accumulator acc
  - sa and sb shift right by one
  - cnt increments
- On the RUN edge with cnt = WIDTH-1:
  - sum <= final acc value, including this edge's s
  - cout <= the carry generated at this edge
  - state -> DONE
- sum and cout change only on that edge. They are stable during RUN and hold the previous result until the next completion.
- A and B are ignored outside the accepting edge. They may change freely during RUN.
- start in RUN or DONE is ignored. It is not queued.
- Reset (rst_n=0, any time, including mid-RUN):
  - immediately forces IDLE
  - busy=0, done=0, sum=0, cout=0
  - clears sa, sb, acc, c, cnt
  - the operation in flight is discarded
- After rst_n deasserts, the first rising edge with start=1 is accepted normally.

## Timing
- Let edge E0 be the accepting edge.
- busy is high from after E0 through the DONE cycle.
- Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- Completion:
  - sum and cout update on edge E_WIDTH.
  - done is high for exactly the one cycle between E_WIDTH and E_WIDTH+1.
  - Latency from start accepted to done = WIDTH cycles.
- At edge E_WIDTH+1 the block returns to IDLE, and done and busy fall.
- The next start is accepted at the earliest on edge E_WIDTH+2. Throughput is one addition per WIDTH+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values: busy=0, done=0, sum=0, cout=0.

## Test plan
- WIDTH=8, A=3, B=5, start pulsed at E0:
  - busy=1 after E0
  - done=1 only between E8 and E9
  - sum=8, cout=0
- A=0xFF, B=0x01: sum=0x00, cout=1 (full carry ripple). A=0xFF, B=0xFF: sum=0xFE, cout=1.
- Start held high continuously with A=0x10, B=0x20, then operands changed to 0x01/0x01 mid-RUN:
  - result is sum=0x30
  - a new op is accepted only at E10
  - done pulses exactly once per op
- rst_n pulled low at E4 of an op (previous result 0x30), then released:
  - immediately busy=0, done=0, sum=0, cout=0
  - no done pulse
  - next op A=7, B=9 gives sum=16
- WIDTH=4, exhaustive over all 256 (A,B) pairs: {cout,sum} == A+B for every pair, done latency = 4 cycles each.
